// File: rtl/piso_tx_ctrl.sv
// Parallel-in / serial-out transmit controller: one word per frame, MSB first, paced by bit_tick.
// Define PISO_TX_PARITY_EN to append a parity bit (even, or odd with ODD_PAR=1) after the data bits.
module piso_tx_ctrl #(
  parameter int WIDTH   = 4,
  parameter int ODD_PAR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             bit_tick,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
`ifdef PISO_TX_PARITY_EN
    PARITY = 2'd2,
`endif
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sreg, sreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               done_n;
`ifdef PISO_TX_PARITY_EN
  logic               par_bit, par_bit_n;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      cnt     <= cnt_n;
      done    <= done_n;
`ifdef PISO_TX_PARITY_EN
      par_bit <= par_bit_n;
`endif
    end
  end

  // Abort outranks bit_tick; an abort seen in IDLE also suppresses that edge's accept.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    cnt_n     = cnt;
    done_n    = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_bit_n = par_bit;
`endif
    case (state)
      IDLE: begin
        if (in_valid && !abort) begin
          state_n   = SHIFT;
          sreg_n    = in_data;
          cnt_n     = CNT_W'(WIDTH - 1);
`ifdef PISO_TX_PARITY_EN
          par_bit_n = (^in_data) ^ (ODD_PAR != 0);
`endif
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (bit_tick) begin
          if (cnt != '0) begin
            sreg_n = {sreg[WIDTH-2:0], 1'b0};
            cnt_n  = cnt - 1'b1;
          end else begin
`ifdef PISO_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        if (abort) begin
          state_n = IDLE;
        end else if (bit_tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ser_out = 1'b0;
    case (state)
      SHIFT:   ser_out = sreg[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
      PARITY:  ser_out = par_bit;
`endif
      default: ser_out = 1'b0;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign ser_valid = (state != IDLE);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: an even-parity and an odd-parity instance checked every cycle against
// a frame-level model, plus directed frames with hand-computed serial bit strings.
module tb_piso_tx_ctrl;
  localparam int WIDTH = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = WIDTH + PAR;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             bit_tick = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready0, ser_out0, ser_valid0, busy0, done0;
  logic in_ready1, ser_out1, ser_valid1, busy1, done1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(WIDTH), .ODD_PAR(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .bit_tick(bit_tick), .abort(abort), .ser_out(ser_out0), .ser_valid(ser_valid0),
    .busy(busy0), .done(done0)
  );

  piso_tx_ctrl #(.WIDTH(WIDTH), .ODD_PAR(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .bit_tick(bit_tick), .abort(abort), .ser_out(ser_out1), .ser_valid(ser_valid1),
    .busy(busy1), .done(done1)
  );

  task automatic check(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Frame model: a frame is the word's bits MSB first, then the parity bit when enabled.
  function automatic logic frame_bit(logic [WIDTH-1:0] w, int pos, int odd);
    if (pos < WIDTH) return w[WIDTH-1-pos];
    return (^w) ^ (odd != 0);
  endfunction

  function automatic logic [31:0] fr(logic [WIDTH-1:0] w, int odd);
    if (PAR != 0) return {{(31-WIDTH){1'b0}}, w, (^w) ^ (odd != 0)};
    return {{(32-WIDTH){1'b0}}, w};
  endfunction

  logic             m_active = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_word = '0;
  int               m_pos = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_pos    <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (in_valid && !abort) begin
          m_active <= 1'b1;
          m_word   <= in_data;
          m_pos    <= 0;
        end
      end else if (abort) begin
        m_active <= 1'b0;
      end else if (bit_tick) begin
        if (m_pos == FL - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready0", in_ready0, !m_active);
    check("busy0", busy0, m_active);
    check("ser_valid0", ser_valid0, m_active);
    check("done0", done0, m_done);
    check("ser_out0", ser_out0, m_active ? frame_bit(m_word, m_pos, 0) : 1'b0);
    check("in_ready1", in_ready1, !m_active);
    check("busy1", busy1, m_active);
    check("ser_valid1", ser_valid1, m_active);
    check("done1", done1, m_done);
    check("ser_out1", ser_out1, m_active ? frame_bit(m_word, m_pos, 1) : 1'b0);
  end

  // Records each serial bit on the cycle a bit_tick consumes it, and counts done pulses.
  logic rec0[$];
  logic rec1[$];
  int   done_cnt0 = 0;
  int   done_cnt1 = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (ser_valid0 && bit_tick && !abort) rec0.push_back(ser_out0);
      if (ser_valid1 && bit_tick && !abort) rec1.push_back(ser_out1);
      if (done0) done_cnt0 <= done_cnt0 + 1;
      if (done1) done_cnt1 <= done_cnt1 + 1;
    end
  end

  task automatic check_frames(string name, input logic q[$], logic [31:0] exp, int n);
    logic [31:0] act;
    logic        ok;
    act = '0;
    foreach (q[i]) act = {act[30:0], q[i]};
    ok = (q.size() == n) && (act == exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s bits: actual=%b (%0d bits) required=%b (%0d bits)", name, act, q.size(), exp, n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    rec0.delete();
    rec1.delete();
  endtask

  task automatic accept(logic [WIDTH-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic run_ticks(int period, string name);
    int c = 0;
    while (busy0 && c < 200) begin
      bit_tick = (c % period == period - 1);
      cyc();
      bit_tick = 1'b0;
      c++;
    end
    check({name, "_timeout"}, busy0, 1'b0);
    cyc();
  endtask

  initial begin
    int base;
    int c;

    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_ser_valid", ser_valid0, 1'b0);
    check("rst_ser_out", ser_out0, 1'b0);
    check("rst_done", done0, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Abort while idle must block the offered word.
    in_data = 4'h3; in_valid = 1'b1; abort = 1'b1;
    cyc();
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_busy", busy0, 1'b0);
    check("abort_idle_ready", in_ready0, 1'b1);

    // Basic frame, tick every 3rd cycle.
    clear_rec();
    base = done_cnt0;
    accept(4'b1011);
    check("basic_busy", busy0, 1'b1);
    check("basic_first_bit", ser_out0, 1'b1);
    run_ticks(3, "basic");
`ifdef PISO_TX_PARITY_EN
    check_frames("basic_even", rec0, 32'b10111, 5);
    check_frames("basic_odd", rec1, 32'b10110, 5);
`else
    check_frames("basic0", rec0, 32'b1011, 4);
    check_frames("basic1", rec1, 32'b1011, 4);
`endif
    check("basic_done_once", done_cnt0 == base + 1, 1'b1);

    // Abort together with a tick after two bits.
    clear_rec();
    base = done_cnt0;
    accept(4'b1100);
    for (int k = 0; k < 4; k++) begin
      bit_tick = (k % 2 == 1);
      cyc();
      bit_tick = 1'b0;
    end
    check("abort_pre_bit", ser_out0, 1'b0);
    abort = 1'b1; bit_tick = 1'b1;
    cyc();
    abort = 1'b0; bit_tick = 1'b0;
    check("abort_busy", busy0, 1'b0);
    check("abort_ser_valid", ser_valid0, 1'b0);
    check("abort_done", done0, 1'b0);
    check("abort_ready", in_ready0, 1'b1);
    cyc();
    check("abort_no_done", done_cnt0 == base, 1'b1);
    check_frames("abort_bits", rec0, 32'b11, 2);
    clear_rec();
    accept(4'h6);
    run_ticks(2, "after_abort");
    check_frames("after_abort0", rec0, fr(4'h6, 0), FL);
    check_frames("after_abort1", rec1, fr(4'h6, 1), FL);
    check("after_abort_done", done_cnt0 == base + 1, 1'b1);

    // Back-to-back: in_valid held high, second word taken on the done cycle.
    clear_rec();
    base = done_cnt0;
    in_data = 4'hA; in_valid = 1'b1;
    cyc();
    in_data = 4'h5;
    c = 0;
    while (done_cnt0 < base + 2 && c < 300) begin
      bit_tick = (c % 2 == 1);
      cyc();
      bit_tick = 1'b0;
      c++;
      if (done_cnt0 == base + 1 && in_valid && busy0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_timeout", done_cnt0 == base + 2, 1'b1);
`ifdef PISO_TX_PARITY_EN
    check_frames("b2b_even", rec0, 32'b1010001010, 10);
    check_frames("b2b_odd", rec1, 32'b1010101011, 10);
`else
    check_frames("b2b0", rec0, 32'b10100101, 8);
    check_frames("b2b1", rec1, 32'b10100101, 8);
`endif
    cyc();

    // Reset mid-frame during the second bit.
    clear_rec();
    base = done_cnt0;
    accept(4'b1011);
    for (int k = 0; k < 3; k++) begin
      bit_tick = (k == 1);
      cyc();
      bit_tick = 1'b0;
    end
    check("rst_mid_pre_bit", ser_out0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ser_out", ser_out0, 1'b0);
    check("rst_mid_ser_valid", ser_valid0, 1'b0);
    check("rst_mid_busy", busy0, 1'b0);
    check("rst_mid_done", done0, 1'b0);
    check("rst_mid_ready", in_ready0, 1'b1);
    @(posedge clk);
    #1;
    clear_rec();
    in_data = 4'h9; in_valid = 1'b1; rst = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("rst_restart_busy", busy0, 1'b1);
    check("rst_no_done", done_cnt0 == base, 1'b1);
    run_ticks(2, "rst_restart");
    check_frames("rst_restart0", rec0, fr(4'h9, 0), FL);
    check_frames("rst_restart1", rec1, fr(4'h9, 1), FL);

    // Stall: no ticks for 20 cycles while another word is offered.
    clear_rec();
    base = done_cnt0;
    accept(4'hC);
    in_data = 4'h3; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("stall_ser_out", ser_out0, 1'b1);
      check("stall_busy", busy0, 1'b1);
      check("stall_ready", in_ready0, 1'b0);
    end
    in_valid = 1'b0;
    run_ticks(3, "stall");
    check_frames("stall0", rec0, fr(4'hC, 0), FL);
    check_frames("stall1", rec1, fr(4'hC, 1), FL);
    check("stall_done_once", done_cnt0 == base + 1, 1'b1);
    check("stall_idle_after", busy0, 1'b0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, parallel word width in bits; legal range 2..32.
REQ-002 SHALL have parameter ODD_PAR, default 0, parity sense: 0 = even, 1 = odd. Used only with PISO_TX_PARITY_EN.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  parallel word offered.
REQ-006 SHALL have port in_data  input  WIDTH  parallel word.
REQ-007 SHALL have port in_ready  output  1  controller can accept a word.
REQ-008 SHALL have port bit_tick  input  1  single-cycle bit-rate strobe.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the current frame.
REQ-010 SHALL have port ser_out  output  1  serial data, MSB first.
REQ-011 SHALL have port ser_valid  output  1  ser_out carries a frame bit.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a frame completes normally.

Function
REQ-014 SHALL implement states IDLE, SHIFT and PARITY; PARITY exists only with PISO_TX_PARITY_EN.
REQ-015 SHALL drive in_ready=1 only in IDLE; busy=1 and ser_valid=1 only in SHIFT or PARITY.
REQ-016 SHALL perform an accept on a rising edge in IDLE with in_valid=1, which:
- captures in_data into an internal WIDTH-bit shift register;
- loads the bit counter with WIDTH-1;
- enters SHIFT.
REQ-017 SHALL ignore bit_tick in IDLE and on the accept edge.
REQ-018 SHALL ignore in_valid and in_data whenever in_ready=0.
REQ-019 SHALL drive ser_out = shift register MSB in SHIFT, giving the first bit (in_data[WIDTH-1]) the cycle after accept.
REQ-020 SHALL, in SHIFT, on each bit_tick with counter>0, shift the register left one place (zero fill) and decrement the counter.
REQ-021 SHALL, in SHIFT, on bit_tick with counter=0, go to PARITY if enabled; otherwise go to IDLE and assert done for exactly the next cycle.
REQ-022 SHALL, in PARITY, drive ser_out = XOR of the captured word, inverted when ODD_PAR=1. On bit_tick it SHALL go to IDLE with the done pulse.
REQ-023 SHALL hold ser_out, the counter and the state unchanged in SHIFT or PARITY when bit_tick=0.
REQ-024 SHALL, on abort=1 in SHIFT or PARITY, go to IDLE on the next edge with no done pulse. Abort SHALL take priority over a simultaneous bit_tick.
REQ-025 SHALL treat abort in IDLE as a no-op, and SHALL block acceptance on that edge.
REQ-026 SHALL drive ser_out=0 whenever ser_valid=0.
REQ-027 SHALL keep at least one IDLE cycle between frames: the done cycle is IDLE and may accept.
REQ-028 SHALL size the counter as $clog2(WIDTH) bits; no wrap occurs because the counter stops at 0.

Reset
REQ-029 SHALL, while rst=0, immediately force: state IDLE, shift register 0, counter 0, ser_out=0, ser_valid=0, busy=0, done=0, in_ready=1.
REQ-030 SHALL abandon a frame on reset mid-frame with no done pulse; a word offered on the first edge after rst rises SHALL be accepted.

Configuration
REQ-031 SHALL compile the PARITY state and the parity bit in when macro PISO_TX_PARITY_EN is defined, making each frame WIDTH+1 bits.
REQ-032 SHALL, without PISO_TX_PARITY_EN, send WIDTH-bit frames; ODD_PAR has no effect and no parity logic is present.

Verification
REQ-033 SHALL cover a basic frame: WIDTH=4, no macro, accept 4'b1011, tick every 3rd cycle -> ser_out 1,0,1,1, then IDLE and done=1 for one cycle.
REQ-034 SHALL cover parity: macro defined, ODD_PAR=0, accept 4'b1011 -> 5 bits 1,0,1,1,1. With ODD_PAR=1 the last bit is 0.
REQ-035 SHALL cover abort: abort together with bit_tick after 2 bits -> IDLE next edge, done stays 0, ser_valid=0, next word accepted normally.
REQ-036 SHALL cover back-to-back: in_valid held high with 4'hA then 4'h5 -> second accept on the done cycle, no lost or duplicated bits.
REQ-037 SHALL cover reset mid-frame: rst low for 1 cycle during bit 2 -> all outputs at reset values immediately, no done, clean restart.
REQ-038 SHALL cover stall: bit_tick held 0 for 20 cycles in SHIFT -> ser_out and busy stable, in_ready=0, in_valid ignored.
